// File: rtl/job_scheduler.sv
// Decompression job scheduler: queues descriptors, launches them one at a time
// into the IO controller and returns one completion record per job in order.
module job_scheduler #(
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [63:0]           job_src_addr,
    input  logic [63:0]           job_des_addr,
    input  logic [34:0]           job_comp_len,
    input  logic [31:0]           job_decomp_len,
    input  logic [7:0]            job_id,
    output logic [63:0]           src_addr,
    output logic [63:0]           des_addr,
    output logic [34:0]           compression_length,
    output logic [31:0]           decompression_length,
    output logic                  start,
    input  logic                  idle,
    input  logic                  done,
    output logic                  cmpl_valid,
    input  logic                  cmpl_ready,
    output logic [7:0]            cmpl_id,
    output logic                  cmpl_skipped,
    output logic                  busy,
    output logic [DEPTH_LOG2:0]   queue_count,
    output logic [31:0]           jobs_done
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    typedef struct packed {
        logic [63:0] src_addr;
        logic [63:0] des_addr;
        logic [34:0] comp_len;
        logic [31:0] decomp_len;
        logic [7:0]  id;
    } desc_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RUN,
        S_REPORT
    } state_t;

    desc_t                 mem [DEPTH];
    desc_t                 in_desc;
    desc_t                 head;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [CW-1:0]         count_next;
    state_t                state;
    state_t                state_next;
    logic                  push;
    logic                  pop;
    logic                  cmpl_hs;

    // Descriptor payload as presented on the input side.
    always_comb begin
        in_desc            = '0;
        in_desc.src_addr   = job_src_addr;
        in_desc.des_addr   = job_des_addr;
        in_desc.comp_len   = job_comp_len;
        in_desc.decomp_len = job_decomp_len;
        in_desc.id         = job_id;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a zero-length head skips the engine entirely.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if ((queue_count != '0) && idle) begin
                    state_next = (head.comp_len == '0) ? S_REPORT : S_LAUNCH;
                end
            end
            S_LAUNCH: state_next = S_WAIT;
            S_WAIT: begin
                if (done) begin
                    state_next = S_REPORT;
                end else if (!idle) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (done) begin
                    state_next = S_REPORT;
                end
            end
            S_REPORT: begin
                if (cmpl_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Queue and handshake controls derived from the current state.
    always_comb begin
        head       = mem[rd_ptr];
        push       = job_valid && job_ready;
        pop        = (state == S_IDLE) && (queue_count != '0) && idle;
        cmpl_hs    = (state == S_REPORT) && cmpl_ready;
        count_next = queue_count;
        case ({push, pop})
            2'b10:   count_next = queue_count + CW'(1);
            2'b01:   count_next = queue_count - CW'(1);
            default: count_next = queue_count;
        endcase
    end

    // Descriptor storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_desc;
        end
    end

    // Circular-buffer pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            queue_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            end
            queue_count <= count_next;
        end
    end

    // Registered outputs: descriptor load, strobes, status and completion count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_addr             <= '0;
            des_addr             <= '0;
            compression_length   <= '0;
            decompression_length <= '0;
            cmpl_id              <= '0;
            cmpl_skipped         <= 1'b0;
            start                <= 1'b0;
            cmpl_valid           <= 1'b0;
            job_ready            <= 1'b1;
            busy                 <= 1'b0;
            jobs_done            <= '0;
        end else begin
            if (pop) begin
                src_addr             <= head.src_addr;
                des_addr             <= head.des_addr;
                compression_length   <= head.comp_len;
                decompression_length <= head.decomp_len;
                cmpl_id              <= head.id;
                cmpl_skipped         <= (head.comp_len == '0);
            end
            start      <= (state_next == S_LAUNCH);
            cmpl_valid <= (state_next == S_REPORT);
            job_ready  <= (count_next < CW'(DEPTH));
            busy       <= (state_next != S_IDLE) || (count_next != '0);
            if (cmpl_hs) begin
                jobs_done <= jobs_done + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_job_scheduler.sv
// Scoreboard bench for job_scheduler: expected launches and completions are
// queued at push time and checked by a monitor on the falling clock edge.
module tb_job_scheduler;

    logic        clk;
    logic        rst;
    logic        job_valid;
    logic        job_ready;
    logic [63:0] job_src_addr;
    logic [63:0] job_des_addr;
    logic [34:0] job_comp_len;
    logic [31:0] job_decomp_len;
    logic [7:0]  job_id;
    logic [63:0] src_addr;
    logic [63:0] des_addr;
    logic [34:0] compression_length;
    logic [31:0] decompression_length;
    logic        start;
    logic        idle;
    logic        done;
    logic        cmpl_valid;
    logic        cmpl_ready;
    logic [7:0]  cmpl_id;
    logic        cmpl_skipped;
    logic        busy;
    logic [2:0]  queue_count;
    logic [31:0] jobs_done;

    typedef struct {
        logic [63:0] src;
        logic [63:0] des;
        logic [34:0] comp;
        logic [31:0] decomp;
        logic [7:0]  id;
    } launch_t;

    typedef struct {
        logic [7:0] id;
        logic       skip;
    } cmpl_t;

    launch_t exp_launch [$];
    cmpl_t   exp_cmpl   [$];
    launch_t mon_l;
    cmpl_t   mon_c;
    int      n_cmp = 0;
    int      n_err = 0;
    int      start_count = 0;

    job_scheduler #(.DEPTH_LOG2(2)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .job_valid            (job_valid),
        .job_ready            (job_ready),
        .job_src_addr         (job_src_addr),
        .job_des_addr         (job_des_addr),
        .job_comp_len         (job_comp_len),
        .job_decomp_len       (job_decomp_len),
        .job_id               (job_id),
        .src_addr             (src_addr),
        .des_addr             (des_addr),
        .compression_length   (compression_length),
        .decompression_length (decompression_length),
        .start                (start),
        .idle                 (idle),
        .done                 (done),
        .cmpl_valid           (cmpl_valid),
        .cmpl_ready           (cmpl_ready),
        .cmpl_id              (cmpl_id),
        .cmpl_skipped         (cmpl_skipped),
        .busy                 (busy),
        .queue_count          (queue_count),
        .jobs_done            (jobs_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [63:0] s, input logic [63:0] d, input logic [34:0] c,
                        input logic [31:0] dl, input logic [7:0] id);
        int t = 0;
        launch_t l;
        cmpl_t   e;
        job_src_addr   = s;
        job_des_addr   = d;
        job_comp_len   = c;
        job_decomp_len = dl;
        job_id         = id;
        job_valid      = 1'b1;
        while (!job_ready && t < 200) begin
            step();
            t++;
        end
        check("push_accept_timeout", 64'(job_ready), 64'd1);
        l.src = s; l.des = d; l.comp = c; l.decomp = dl; l.id = id;
        e.id = id; e.skip = (c == 35'd0);
        if (c != 35'd0) exp_launch.push_back(l);
        exp_cmpl.push_back(e);
        step();
        job_valid = 1'b0;
    endtask

    task automatic run_job(input int busy_cycles);
        int t = 0;
        while (!start && t < 200) begin
            step();
            t++;
        end
        check("run_job_start_seen", 64'(start), 64'd1);
        step();
        check("start_one_cycle", 64'(start), 64'd0);
        idle = 1'b0;
        repeat (busy_cycles) step();
        done = 1'b1;
        step();
        done = 1'b0;
        idle = 1'b1;
        check("cmpl_valid_after_done", 64'(cmpl_valid), 64'd1);
    endtask

    task automatic wait_jobs(input logic [31:0] target);
        int t = 0;
        while (jobs_done != target && t < 300) begin
            step();
            t++;
        end
        check("jobs_done", 64'(jobs_done), 64'(target));
    endtask

    // Monitor: checks every launch and every completion handshake against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (start) begin
                start_count++;
                check("start_while_cmpl_valid", 64'(cmpl_valid), 64'd0);
                if (exp_launch.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_start: actual id 0x%0h required none", cmpl_id);
                end else begin
                    mon_l = exp_launch.pop_front();
                    check("launch_src", src_addr, mon_l.src);
                    check("launch_des", des_addr, mon_l.des);
                    check("launch_comp", 64'(compression_length), 64'(mon_l.comp));
                    check("launch_decomp", 64'(decompression_length), 64'(mon_l.decomp));
                    check("launch_id", 64'(cmpl_id), 64'(mon_l.id));
                end
            end
            if (cmpl_valid && cmpl_ready) begin
                if (exp_cmpl.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_cmpl: actual id 0x%0h required none", cmpl_id);
                end else begin
                    mon_c = exp_cmpl.pop_front();
                    check("cmpl_id", 64'(cmpl_id), 64'(mon_c.id));
                    check("cmpl_skipped", 64'(cmpl_skipped), 64'(mon_c.skip));
                end
            end
        end
    end

    // Runaway guard.
    initial begin
        #400000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sc;
        int n;
        rst = 1'b1; job_valid = 1'b0; idle = 1'b1; done = 1'b0; cmpl_ready = 1'b1;
        job_src_addr = '0; job_des_addr = '0; job_comp_len = '0; job_decomp_len = '0; job_id = '0;
        repeat (3) step();
        check("rst_start", 64'(start), 64'd0);
        check("rst_cmpl_valid", 64'(cmpl_valid), 64'd0);
        check("rst_job_ready", 64'(job_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_queue_count", 64'(queue_count), 64'd0);
        check("rst_jobs_done", 64'(jobs_done), 64'd0);
        check("rst_src_addr", src_addr, 64'd0);
        check("rst_cmpl_id", 64'(cmpl_id), 64'd0);
        rst = 1'b0;
        step();

        // Single job with exact launch latency.
        push(64'h1000, 64'h8000, 35'd5000, 32'd9000, 8'h11);
        check("t1_no_start_edge1", 64'(start), 64'd0);
        check("t1_count_after_push", 64'(queue_count), 64'd1);
        step();
        check("t1_start_edge2", 64'(start), 64'd1);
        check("t1_count_after_pop", 64'(queue_count), 64'd0);
        step();
        check("t1_start_dropped", 64'(start), 64'd0);
        idle = 1'b0;
        repeat (7) step();
        check("t1_busy_run", 64'(busy), 64'd1);
        check("t1_no_cmpl_yet", 64'(cmpl_valid), 64'd0);
        done = 1'b1;
        step();
        done = 1'b0;
        idle = 1'b1;
        check("t1_cmpl_valid", 64'(cmpl_valid), 64'd1);
        step();
        check("t1_cmpl_cleared", 64'(cmpl_valid), 64'd0);
        check("t1_jobs_done", 64'(jobs_done), 64'd1);
        check("t1_busy_clear", 64'(busy), 64'd0);

        // Fill the queue while the engine is busy, then drain in order.
        idle = 1'b0;
        for (int i = 1; i <= 4; i++)
            push(64'(i) << 12, 64'(i) << 20, 35'(i * 100), 32'(i * 300), 8'(i));
        check("fill_count", 64'(queue_count), 64'd4);
        check("fill_not_ready", 64'(job_ready), 64'd0);
        check("fill_no_start", 64'(start_count), 64'd1);
        fork
            push(64'h5000, 64'h500000, 35'd500, 32'd1500, 8'd5);
            begin
                idle = 1'b1;
                for (int j = 0; j < 5; j++) run_job(3);
            end
        join
        wait_jobs(32'd6);

        // Zero-length job bypasses the engine.
        sc = start_count;
        push(64'h2200, 64'h2200, 35'd0, 32'd64, 8'h22);
        wait_jobs(32'd7);
        check("zero_no_start", 64'(start_count), 64'(sc));

        // done arrives while still in the wait state.
        push(64'h3300, 64'h33000, 35'd10, 32'd20, 8'h33);
        n = 0;
        while (!start && n < 50) begin
            step();
            n++;
        end
        step();
        done = 1'b1;
        step();
        done = 1'b0;
        check("wait_done_cmpl", 64'(cmpl_valid), 64'd1);
        wait_jobs(32'd8);

        // Completion backpressure with a second job pending.
        cmpl_ready = 1'b0;
        push(64'h4100, 64'h41000, 35'd41, 32'd82, 8'h41);
        push(64'h4200, 64'h42000, 35'd42, 32'd84, 8'h42);
        run_job(3);
        sc = start_count;
        repeat (20) begin
            step();
            check("bp_cmpl_valid", 64'(cmpl_valid), 64'd1);
            check("bp_cmpl_id", 64'(cmpl_id), 64'h41);
        end
        check("bp_no_second_start", 64'(start_count), 64'(sc));
        cmpl_ready = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (!start && n < 5);
        check("bp_restart_latency", 64'(n), 64'd2);
        run_job(3);
        wait_jobs(32'd10);

        // Reset during a running job with three queued.
        push(64'h5100, 64'h51000, 35'd51, 32'd51, 8'h51);
        n = 0;
        while (!start && n < 50) begin
            step();
            n++;
        end
        step();
        idle = 1'b0;
        step();
        for (int k = 2; k <= 4; k++)
            push(64'h5000 + 64'(k), 64'h50000, 35'd5, 32'd5, 8'(8'h50 + k));
        check("rst_mid_count", 64'(queue_count), 64'd3);
        rst = 1'b1;
        #1;
        check("rst_mid_queue_count", 64'(queue_count), 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_job_ready", 64'(job_ready), 64'd1);
        check("rst_mid_jobs_done", 64'(jobs_done), 64'd0);
        check("rst_mid_src", src_addr, 64'd0);
        check("rst_mid_comp", 64'(compression_length), 64'd0);
        exp_launch.delete();
        exp_cmpl.delete();
        idle = 1'b1;
        done = 1'b0;
        step();
        step();
        rst = 1'b0;
        sc = start_count;
        repeat (5) begin
            step();
            check("post_rst_no_cmpl", 64'(cmpl_valid), 64'd0);
        end
        check("post_rst_no_start", 64'(start_count), 64'(sc));
        push(64'h6100, 64'h61000, 35'd61, 32'd122, 8'h61);
        run_job(3);
        wait_jobs(32'd1);

        repeat (3) step();
        check("launch_queue_drained", 64'(exp_launch.size()), 64'd0);
        check("cmpl_queue_drained", 64'(exp_cmpl.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
